mmc1_serial_writer: RTL and testbench

Bus-side transmitter for the MMC1 serial register protocol. It converts a parallel command (register select, 5-bit value, optional shift-register reset) into the NES CPU write cycles the mapper expects:
- an optional reset write with D7=1;
- five writes carrying D0 LSB first, addressed to $8000/$A000/$C000/$E000.

It drives a free-running M2 and inserts idle bus cycles so the mapper never sees consecutive-cycle writes. It sits between a test/loader controller and the mapper model's CPU pins, both in the bench and in FPGA cart loaders.

---
 rtl/mmc1_pkg.sv | 30 +++
 rtl/mmc1_serial_writer_if.sv | 22 ++
 rtl/mmc1_m2_gen.sv | 35 +++
 rtl/mmc1_serial_writer.sv | 121 ++++++++++++
 tb/tb_mmc1_serial_writer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 serial register writer.
// Holds the FSM state encoding, register selects and payload helpers.
package mmc1_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_RST_WR,
        S_BIT_WR,
        S_GAP
    } state_t;

    typedef logic [1:0] reg_sel_t;

    localparam reg_sel_t REG_CTRL = 2'd0;
    localparam reg_sel_t REG_CHR0 = 2'd1;
    localparam reg_sel_t REG_CHR1 = 2'd2;
    localparam reg_sel_t REG_PRG  = 2'd3;

    localparam int SHIFT_LEN = 5;
    localparam logic [7:0] RESET_DATA = 8'h80;

    function automatic logic [7:0] bit_payload(
        input logic [4:0] data,
        input logic [2:0] k
    );
        return {7'b0, data[k]};
    endfunction

endpackage

// File: rtl/mmc1_serial_writer_if.sv
// Command handshake between a loader/test controller and the writer.
// master = controller side, slave = writer side.
interface mmc1_serial_writer_if;

    logic                cmd_valid;
    logic                cmd_ready;
    mmc1_pkg::reg_sel_t  cmd_reg;
    logic [4:0]          cmd_data;
    logic                cmd_reset;
    logic                done;

    modport master (
        output cmd_valid, cmd_reg, cmd_data, cmd_reset,
        input  cmd_ready, done
    );

    modport slave (
        input  cmd_valid, cmd_reg, cmd_data, cmd_reset,
        output cmd_ready, done
    );

endinterface

// File: rtl/mmc1_m2_gen.sv
// Free-running M2 divider: HALF_PER clk low, HALF_PER clk high.
// Strobes mark the edge that opens the low (cyc_start) or high phase.
module mmc1_m2_gen #(
    parameter int HALF_PER = 2
) (
    input  logic clk,
    input  logic rst,
    output logic m2,
    output logic cyc_start,
    output logic hi_start
);

    localparam int PER = 2 * HALF_PER;
    localparam int CW  = (PER > 2) ? $clog2(PER) : 1;

    logic [CW-1:0] cnt;

    // Pre-decoded so registers loaded on this edge line up with m2.
    assign cyc_start = (cnt == CW'(PER - 1));
    assign hi_start  = (cnt == CW'(HALF_PER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            m2  <= 1'b0;
        end else begin
            cnt <= cyc_start ? '0 : cnt + 1'b1;
            if (hi_start)
                m2 <= 1'b1;
            else if (cyc_start)
                m2 <= 1'b0;
        end
    end

endmodule

// File: rtl/mmc1_serial_writer.sv
// Turns a parallel MMC1 register command into paced CPU write cycles:
// optional D7 reset write, then five LSB-first D0 writes, each followed by idle cycles.
module mmc1_serial_writer
    import mmc1_pkg::*;
#(
    parameter int HALF_PER = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mmc1_serial_writer_if.slave  cmd,
    output logic                 m2,
    output logic [14:0]          cpu_a,
    output logic [7:0]           cpu_d,
    output logic                 cpu_rw_n,
    output logic                 romsel_n
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic          cyc_start;
    logic          hi_start;
    state_t        state;
    reg_sel_t      reg_q;
    logic [4:0]    data_q;
    logic          rst_q;
    logic [2:0]    k;
    logic [GW-1:0] gcnt;

    mmc1_m2_gen #(
        .HALF_PER (HALF_PER)
    ) u_m2 (
        .clk       (clk),
        .rst       (rst),
        .m2        (m2),
        .cyc_start (cyc_start),
        .hi_start  (hi_start)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            reg_q         <= REG_CTRL;
            data_q        <= '0;
            rst_q         <= 1'b0;
            k             <= '0;
            gcnt          <= '0;
            cpu_a         <= '0;
            cpu_d         <= '0;
            cpu_rw_n      <= 1'b1;
            romsel_n      <= 1'b1;
            cmd.cmd_ready <= 1'b0;
            cmd.done      <= 1'b0;
        end else begin
            cmd.done <= 1'b0;

            // /ROMSEL follows M2 high, but only inside a write cycle.
            if (hi_start)
                romsel_n <= !(state == S_RST_WR || state == S_BIT_WR);
            else if (cyc_start)
                romsel_n <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        reg_q         <= cmd.cmd_reg;
                        data_q        <= cmd.cmd_data;
                        rst_q         <= cmd.cmd_reset;
                        cmd.cmd_ready <= 1'b0;
                        state         <= S_ALIGN;
                    end else begin
                        cmd.cmd_ready <= 1'b1;
                    end
                end
                S_ALIGN: begin
                    if (cyc_start) begin
                        k        <= '0;
                        cpu_a    <= {reg_q, 13'b0};
                        cpu_rw_n <= 1'b0;
                        if (rst_q) begin
                            cpu_d <= RESET_DATA;
                            state <= S_RST_WR;
                        end else begin
                            cpu_d <= bit_payload(data_q, 3'd0);
                            state <= S_BIT_WR;
                        end
                    end
                end
                S_RST_WR, S_BIT_WR: begin
                    if (cyc_start) begin
                        if (state == S_BIT_WR)
                            k <= k + 3'd1;
                        gcnt     <= '0;
                        cpu_a    <= '0;
                        cpu_d    <= '0;
                        cpu_rw_n <= 1'b1;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cyc_start) begin
                        if (gcnt != GW'(GAP_CYC - 1)) begin
                            gcnt <= gcnt + 1'b1;
                        end else if (k == 3'(SHIFT_LEN)) begin
                            cmd.done      <= 1'b1;
                            cmd.cmd_ready <= 1'b1;
                            state         <= S_IDLE;
                        end else begin
                            cpu_a    <= {reg_q, 13'b0};
                            cpu_d    <= bit_payload(data_q, k);
                            cpu_rw_n <= 1'b0;
                            state    <= S_BIT_WR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Bench for mmc1_serial_writer: directed vector table plus multi-cycle sequences,
// two instances (HALF_PER=2/GAP_CYC=1 and HALF_PER=1/GAP_CYC=3) and a small mapper model.
module tb_mmc1_serial_writer;

    typedef struct {
        bit          rr;
        logic [1:0]  r;
        logic [4:0]  d;
        logic [14:0] ea;
        int          len;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmc1_serial_writer_if ifa ();
    mmc1_serial_writer_if ifb ();

    logic        m2_a, rw_a, rs_a;
    logic [14:0] a_a;
    logic [7:0]  d_a;
    logic        m2_b, rw_b, rs_b;
    logic [14:0] a_b;
    logic [7:0]  d_b;

    mmc1_serial_writer #(.HALF_PER(2), .GAP_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .cmd(ifa), .m2(m2_a), .cpu_a(a_a),
        .cpu_d(d_a), .cpu_rw_n(rw_a), .romsel_n(rs_a)
    );

    mmc1_serial_writer #(.HALF_PER(1), .GAP_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .cmd(ifb), .m2(m2_b), .cpu_a(a_b),
        .cpu_d(d_b), .cpu_rw_n(rw_b), .romsel_n(rs_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_fail = 0;
    int          nw[2] = '{0, 0};
    int          rs_cnt[2] = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          done_t[2] = '{0, 0};
    logic        prev_rw[2] = '{1'b1, 1'b1};
    logic        prev_rs[2] = '{1'b1, 1'b1};
    logic [14:0] wr_a[2][16];
    logic [7:0]  wr_d[2][16];
    int          wr_t[2][16];
    logic [4:0]  sr = '0;
    int          sc = 0;
    logic [4:0]  mreg[4] = '{5'h0, 5'h0, 5'h0, 5'h0};

    task automatic observe(input int u, input logic rw, input logic rs,
                           input logic [14:0] a, input logic [7:0] d,
                           input logic dn);
        if (!rw && prev_rw[u]) begin
            if (nw[u] < 16) begin
                wr_a[u][nw[u]] = a;
                wr_d[u][nw[u]] = d;
                wr_t[u][nw[u]] = cyc;
            end
            nw[u]++;
        end
        if (!rs && prev_rs[u]) begin
            rs_cnt[u]++;
            // Mapper shift register: D7 clears, otherwise shift D0 in from the top.
            if (u == 0) begin
                if (d[7]) begin
                    sr = '0;
                    sc = 0;
                end else begin
                    sr = {d[0], sr[4:1]};
                    sc++;
                    if (sc == 5) begin
                        mreg[a[14:13]] = sr;
                        sr = '0;
                        sc = 0;
                    end
                end
            end
        end
        if (dn) begin
            done_cnt[u]++;
            done_t[u] = cyc;
        end
        prev_rw[u] = rw;
        prev_rs[u] = rs;
    endtask

    always @(negedge clk) observe(0, rw_a, rs_a, a_a, d_a, ifa.done);
    always @(negedge clk) observe(1, rw_b, rs_b, a_b, d_b, ifb.done);

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input int u, input logic v, input logic rr,
                           input logic [1:0] r, input logic [4:0] d);
        if (u == 0) begin
            ifa.cmd_valid = v; ifa.cmd_reset = rr;
            ifa.cmd_reg = r;   ifa.cmd_data = d;
        end else begin
            ifb.cmd_valid = v; ifb.cmd_reset = rr;
            ifb.cmd_reg = r;   ifb.cmd_data = d;
        end
    endtask

    function automatic logic rdy(input int u);
        return (u == 0) ? ifa.cmd_ready : ifb.cmd_ready;
    endfunction

    task automatic clr(input int u);
        nw[u] = 0;
        rs_cnt[u] = 0;
    endtask

    task automatic send(input int u, input logic rr, input logic [1:0] r,
                        input logic [4:0] d, output int acc);
        int n = 0;
        set_cmd(u, 1'b1, rr, r, d);
        while (rdy(u) !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("accept_wait", n < 100, 1);
        tick();
        acc = cyc;
        set_cmd(u, 1'b0, rr, r, d);
    endtask

    task automatic wait_done(input int u, input int prev);
        int n = 0;
        while (done_cnt[u] == prev && n < 400) begin
            tick();
            n++;
        end
        check("done_wait", n < 400, 1);
    endtask

    task automatic run_vec(input int u, input vec_t v, input int spc,
                           input int lat_max);
        int acc, d0, off, nexp;
        clr(u);
        d0 = done_cnt[u];
        send(u, v.rr, v.r, v.d, acc);
        wait_done(u, d0);
        off  = v.rr ? 1 : 0;
        nexp = 5 + off;
        check("n_writes", nw[u], nexp);
        check("romsel_lows", rs_cnt[u], nexp);
        check("align_latency",
              (wr_t[u][0] - acc >= 1) && (wr_t[u][0] - acc <= lat_max), 1);
        if (v.rr) begin
            check("rst_wr_d", wr_d[u][0], 8'h80);
            check("rst_wr_a", wr_a[u][0], v.ea);
        end
        for (int i = 0; i < 5; i++) begin
            check("bit_wr_a", wr_a[u][off+i], v.ea);
            check("bit_wr_d", wr_d[u][off+i], {7'b0, v.d[i]});
        end
        for (int i = 1; i < nexp; i++)
            check("wr_spacing", wr_t[u][i] - wr_t[u][i-1], spc);
        check("done_len", done_t[u] - wr_t[u][0], v.len);
        check("done_once", done_cnt[u] - d0, 1);
        if (u == 0)
            check("mapper_reg", mreg[v.r], v.d);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t vb;
        int   acc, d0, dA, n;
        logic pm;

        vecs[0] = '{1'b0, 2'd3, 5'b10110, 15'h6000, 40};
        vecs[1] = '{1'b1, 2'd0, 5'h0C,    15'h0000, 48};
        vecs[2] = '{1'b0, 2'd1, 5'b11111, 15'h2000, 40};
        vecs[3] = '{1'b1, 2'd2, 5'b00000, 15'h4000, 48};
        vecs[4] = '{1'b0, 2'd0, 5'b00001, 15'h0000, 40};
        vb      = '{1'b0, 2'd3, 5'b10110, 15'h6000, 40};

        set_cmd(0, 1'b0, 1'b0, 2'd0, 5'd0);
        set_cmd(1, 1'b0, 1'b0, 2'd0, 5'd0);
        repeat (3) tick();

        check("rst_m2", m2_a, 0);
        check("rst_cpu_a", a_a, 0);
        check("rst_cpu_d", d_a, 0);
        check("rst_rw_n", rw_a, 1);
        check("rst_romsel_n", rs_a, 1);
        check("rst_done", ifa.done, 0);
        check("rst_ready", ifa.cmd_ready, 0);
        check("rst_m2_b", m2_b, 0);

        rst = 1'b0;
        tick();
        check("ready_after_rst", ifa.cmd_ready, 1);
        check("ready_after_rst_b", ifb.cmd_ready, 1);

        for (int i = 0; i < 4; i++) begin
            pm = m2_b;
            tick();
            check("m2b_toggle", m2_b, !pm);
        end

        for (int i = 0; i < 5; i++)
            run_vec(0, vecs[i], 8, 4);

        // Back-to-back: cmd_valid held high across two commands.
        clr(0);
        d0 = done_cnt[0];
        set_cmd(0, 1'b1, 1'b0, 2'd3, 5'b10101);
        n = 0;
        while (ifa.cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        set_cmd(0, 1'b1, 1'b0, 2'd2, 5'b01010);
        wait_done(0, d0);
        dA = done_t[0];
        check("b2b_ready_at_done", ifa.cmd_ready, 1);
        tick();
        set_cmd(0, 1'b0, 1'b0, 2'd2, 5'b01010);
        wait_done(0, d0 + 1);
        check("b2b_writes", nw[0], 10);
        check("b2b_romsel_lows", rs_cnt[0], 10);
        check("b2b_second_start", wr_t[0][5] - dA, 4);
        check("b2b_second_len", done_t[0] - wr_t[0][5], 40);
        for (int i = 1; i < 10; i++)
            check("b2b_not_adjacent", wr_t[0][i] - wr_t[0][i-1] >= 8, 1);
        for (int i = 0; i < 5; i++) begin
            check("b2b_a1", wr_a[0][i], 15'h6000);
            check("b2b_a2", wr_a[0][5+i], 15'h4000);
        end
        check("b2b_d1", {wr_d[0][4][0], wr_d[0][3][0], wr_d[0][2][0],
                         wr_d[0][1][0], wr_d[0][0][0]}, 5'b10101);
        check("b2b_d2", {wr_d[0][9][0], wr_d[0][8][0], wr_d[0][7][0],
                         wr_d[0][6][0], wr_d[0][5][0]}, 5'b01010);

        // cmd_valid pulsed while busy must be ignored.
        clr(0);
        d0 = done_cnt[0];
        send(0, 1'b0, 2'd1, 5'b10011, acc);
        n = 0;
        while (nw[0] < 1 && n < 100) begin tick(); n++; end
        check("busy_first_write", n < 100, 1);
        set_cmd(0, 1'b1, 1'b0, 2'd2, 5'b01100);
        check("busy_ready_low", ifa.cmd_ready, 0);
        tick();
        check("busy_ready_low2", ifa.cmd_ready, 0);
        set_cmd(0, 1'b0, 1'b0, 2'd2, 5'b01100);
        wait_done(0, d0);
        repeat (30) tick();
        check("busy_writes", nw[0], 5);
        check("busy_dones", done_cnt[0] - d0, 1);
        check("busy_idle_ready", ifa.cmd_ready, 1);
        for (int i = 0; i < 5; i++)
            check("busy_a", wr_a[0][i], 15'h2000);
        check("busy_d", {wr_d[0][4][0], wr_d[0][3][0], wr_d[0][2][0],
                         wr_d[0][1][0], wr_d[0][0][0]}, 5'b10011);

        // Reset in the middle of the k=2 write.
        clr(0);
        d0 = done_cnt[0];
        send(0, 1'b0, 2'd3, 5'b11111, acc);
        n = 0;
        while (nw[0] < 3 && n < 200) begin tick(); n++; end
        check("mid_reach_k2", n < 200, 1);
        check("mid_in_write", rw_a, 0);
        rst = 1'b1;
        #1;
        check("mid_rw_n", rw_a, 1);
        check("mid_romsel_n", rs_a, 1);
        check("mid_cpu_a", a_a, 0);
        check("mid_cpu_d", d_a, 0);
        check("mid_m2", m2_a, 0);
        check("mid_ready", ifa.cmd_ready, 0);
        check("mid_done", ifa.done, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (30) tick();
        check("mid_no_done", done_cnt[0] - d0, 0);
        check("mid_ready_after", ifa.cmd_ready, 1);
        vecs[0] = '{1'b1, 2'd3, 5'b01001, 15'h6000, 48};
        run_vec(0, vecs[0], 8, 4);

        // Fast M2, long gap instance.
        run_vec(1, vb, 8, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
